// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard/stall controller: FSM encodings,
// the hardwired-zero register index and default parameter values.
package hazard_pkg;

    typedef logic [1:0] hazard_state_t;

    localparam hazard_state_t ST_IDLE    = 2'd0;
    localparam hazard_state_t ST_BUSY    = 2'd1;
    localparam hazard_state_t ST_RELEASE = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEFAULT_MULDIV_LATENCY = 4;
    localparam int DEFAULT_STALL_CNT_W    = 16;

    // A source operand depends on a destination only if they match and the
    // destination is not $zero, whose writes are discarded.
    function automatic logic reg_depends(input logic [4:0] dest, input logic [4:0] src);
        return (dest == src) && (dest != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_load_use_detect.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID is about to read.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_WriteReg,
    output logic       Hazard
);

    logic rs_dep_s;
    logic rt_dep_s;

    // Compare the EX destination against both ID sources.
    always_comb begin
        rs_dep_s = reg_depends(EX_WriteReg, ID_Rs);
        rt_dep_s = ID_UsesRt && reg_depends(EX_WriteReg, ID_Rt);
        if (EX_MemRead) begin
            Hazard = rs_dep_s || rt_dep_s;
        end else begin
            Hazard = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: drives PC / IF/ID / ID/EX enables and flushes for
// load-use stalls, taken branches and multi-cycle mult/div occupancy of EX.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
    parameter int STALL_CNT_W    = DEFAULT_STALL_CNT_W
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRt,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_WriteReg,
    input  logic                   EX_MulDiv,
    input  logic                   BranchTaken,
    output logic                   PCWrite,
    output logic                   IFID_WriteEnable,
    output logic                   IFID_Flush,
    output logic                   IDEX_WriteEnable,
    output logic                   IDEX_Flush,
    output logic                   EXMEM_Flush,
    output logic                   Busy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int CNT_W = $clog2(MULDIV_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    // The issue cycle is itself a stall cycle, so BUSY covers LATENCY-2 more.
    localparam logic [CNT_W-1:0] CNT_START = (MULDIV_LATENCY > 2) ?
                                             CNT_W'(MULDIV_LATENCY - 2) : CNT_ZERO;
    localparam bit MULDIV_EN    = (MULDIV_LATENCY >= 2);
    localparam bit MULDIV_SHORT = (MULDIV_LATENCY == 2);
    localparam logic [STALL_CNT_W-1:0] STALL_ZERO = {STALL_CNT_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE  = STALL_CNT_W'(32'd1);

    hazard_state_t          state_r;
    hazard_state_t          state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic [STALL_CNT_W-1:0] stall_count_r;
    logic                   load_use_s;

    load_use_detect u_load_use_detect (
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UsesRt   (ID_UsesRt),
        .EX_MemRead  (EX_MemRead),
        .EX_WriteReg (EX_WriteReg),
        .Hazard      (load_use_s)
    );

    // Same-cycle control outputs and next-state selection, in priority order.
    always_comb begin
        PCWrite          = 1'b1;
        IFID_WriteEnable = 1'b1;
        IFID_Flush       = 1'b0;
        IDEX_WriteEnable = 1'b1;
        IDEX_Flush       = 1'b0;
        EXMEM_Flush      = 1'b0;
        Busy             = 1'b0;
        state_nxt_s      = ST_IDLE;
        cnt_nxt_s        = cnt_r;

        if (Reset) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_BUSY: begin
                    PCWrite          = 1'b0;
                    IFID_WriteEnable = 1'b0;
                    IDEX_WriteEnable = 1'b0;
                    EXMEM_Flush      = 1'b1;
                    Busy             = 1'b1;
                    cnt_nxt_s        = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_RELEASE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_IDLE, ST_RELEASE: begin
                    // In RELEASE the completing mult/div still shows EX_MulDiv.
                    if (BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Flush  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (MULDIV_EN && EX_MulDiv && (state_r == ST_IDLE)) begin
                        PCWrite          = 1'b0;
                        IFID_WriteEnable = 1'b0;
                        IDEX_WriteEnable = 1'b0;
                        EXMEM_Flush      = 1'b1;
                        Busy             = 1'b1;
                        if (MULDIV_SHORT) begin
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = ST_RELEASE;
                        end else begin
                            cnt_nxt_s   = CNT_START;
                            state_nxt_s = ST_BUSY;
                        end
                    end else if (load_use_s) begin
                        PCWrite          = 1'b0;
                        IFID_WriteEnable = 1'b0;
                        IDEX_Flush       = 1'b1;
                        state_nxt_s      = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state, occupancy down-counter and saturating stall counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            stall_count_r <= STALL_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (!PCWrite && !(&stall_count_r)) begin
                stall_count_r <= stall_count_r + STALL_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign StallCount = stall_count_r;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Hazard and stall controller that drives the write-enable and flush inputs of the IF/ID and ID/EX stage registers and the PC.
- It is the producer side of the stage-register WriteEnable/Reset interface.
- Detects load-use hazards, taken branches/jumps resolved in EX, and multi-cycle mult/div occupancy of EX.
- Generates same-cycle stall and flush controls and keeps a saturating stall-cycle counter.

Parameters:
MULDIV_LATENCY, 4, cycles a mult/div occupies EX (must be >= 1); stall cycles = MULDIV_LATENCY-1
STALL_CNT_W, 16, width of the stall performance counter

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
ID_Rs  in  5  rs field of instruction in ID
ID_Rt  in  5  rt field of instruction in ID
ID_UsesRt  in  1  ID instruction reads rt as a source
EX_MemRead  in  1  instruction in EX is a load (MemRead_Out of ID/EX)
EX_WriteReg  in  5  destination register of the EX instruction
EX_MulDiv  in  1  instruction in EX is mult/div
BranchTaken  in  1  branch taken or jump resolved in EX this cycle
PCWrite  out  1  PC update enable
IFID_WriteEnable  out  1  IF/ID register write enable
IFID_Flush  out  1  clear IF/ID to NOP next edge
IDEX_WriteEnable  out  1  ID/EX register write enable
IDEX_Flush  out  1  load bubble (all controls 0) into ID/EX next edge
EXMEM_Flush  out  1  load bubble into EX/MEM next edge
Busy  out  1  mult/div stall in progress
StallCount  out  STALL_CNT_W  cycles with PCWrite=0 since reset, saturating

Behaviour:
- States: IDLE, BUSY, RELEASE. Down-counter Cnt, width clog2(MULDIV_LATENCY)+1.
- Outputs are combinational from state and inputs (same-cycle effect). Cnt, state and StallCount are registered.
- Default (no hazard):
  - PCWrite = IFID_WriteEnable = IDEX_WriteEnable = 1.
  - All flushes = 0. Busy = 0.
- Reset asserted:
  - Outputs forced to the default values.
  - Next edge: state = IDLE, Cnt = 0, StallCount = 0.
  - Reset mid-BUSY aborts the stall immediately.
- Priority within a cycle: Reset > BUSY > BranchTaken > EX_MulDiv start > load-use.
- BUSY:
  - PCWrite = 0, IFID_WriteEnable = 0, IDEX_WriteEnable = 0, EXMEM_Flush = 1, Busy = 1.
  - Cnt decrements each cycle; if Cnt == 1, next state = RELEASE.
  - BranchTaken, EX_MulDiv and load-use are ignored.
- RELEASE:
  - Default outputs; the mult/div completes and ID/EX advances.
  - EX_MulDiv is ignored (it is still high for the completing instruction).
  - Next state = IDLE. BranchTaken and load-use are evaluated as in IDLE.
- IDLE, BranchTaken = 1:
  - IFID_Flush = 1, IDEX_Flush = 1; PC and register enables stay 1.
  - No stall is counted.
- IDLE, EX_MulDiv = 1, MULDIV_LATENCY >= 2:
  - Stall outputs as in BUSY for this cycle.
  - If MULDIV_LATENCY == 2: next state = RELEASE.
  - Otherwise: Cnt <= MULDIV_LATENCY-2, next state = BUSY.
  - Total stall = MULDIV_LATENCY-1 consecutive cycles.
- MULDIV_LATENCY == 1: EX_MulDiv is ignored entirely.
- Load-use: EX_MemRead && EX_WriteReg != 0 && (EX_WriteReg == ID_Rs || (ID_UsesRt && EX_WriteReg == ID_Rt)).
  - Response: PCWrite = 0, IFID_WriteEnable = 0, IDEX_Flush = 1, IDEX_WriteEnable = 1.
  - Exactly one bubble; the next cycle has a bubble in EX, so there is no repeat.
- Register $zero never creates a hazard.
- StallCount increments on every non-reset cycle with PCWrite = 0 and saturates at all-ones (no wrap).

Decomposition:
- hazard_pkg:
  - State enum (IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2).
  - REG_ZERO = 5'd0.
  - Default MULDIV_LATENCY.
- Sub-module load_use_detect: the combinational comparator producing a single hazard bit; instantiated once.

Test Plan:
1. Load-use on rs: EX_MemRead = 1, EX_WriteReg = 8, ID_Rs = 8 -> PCWrite = 0, IFID_WriteEnable = 0, IDEX_Flush = 1 for exactly 1 cycle; StallCount 0 -> 1. Repeat with ID_Rt = 8, ID_UsesRt = 0 -> no stall.
2. Zero register: EX_MemRead = 1, EX_WriteReg = 0, ID_Rs = 0 -> all defaults, StallCount unchanged.
3. Mult/div, MULDIV_LATENCY = 4: EX_MulDiv held high 4 cycles -> Busy/stall outputs for cycles 1-3, cycle 4 defaults (RELEASE), then IDLE; StallCount = 3. Repeat at MULDIV_LATENCY = 2 (1 stall) and = 1 (0 stalls).
4. Branch with load-use in the same cycle: BranchTaken = 1 plus load-use match -> IFID_Flush = 1, IDEX_Flush = 1, PCWrite = 1, no stall counted.
5. Reset in BUSY: assert Reset during the 2nd stall cycle -> that cycle outputs are defaults; next cycle state IDLE, Busy = 0, StallCount = 0.
6. Saturation: STALL_CNT_W = 2, six mult/div stall cycles -> StallCount stops at 3.
